// File: rtl/demux1to2048_wr_n.sv
// rtl/demux1to2048_wr_n.sv - pipelined 1-to-2**address write demux into a registered entry array with bulk clear
module demux1to2048_wr_n #(
  parameter int n       = 4,
  parameter int address = 11,
  parameter int gr      = 2,
  parameter int m       = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [address-1:0]   wr_addr_i,
  input  logic [n-1:0]         wr_data_i,
  input  logic                 clr_i,
  output logic                 busy_o,
  output logic                 wr_done_o,
  output logic [n-1:0]         data_o [0:2**address-1]
);

  localparam int iw = $clog2(m);
  localparam int gw = address - iw;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [address-1:0]   clr_cnt;

  logic                 s1_valid;
  logic [address-1:0]   s1_addr;
  logic [n-1:0]         s1_data;

  logic                 s2_valid;
  logic [gr-1:0]        s2_grp;
  logic [iw-1:0]        s2_idx;
  logic [n-1:0]         s2_data;

  logic [gw-1:0]        grp_bin;
  logic [address-1:0]   wr_index;

  assign wr_ready_o = (state_q == IDLE) && !clr_i;
  assign busy_o     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_i) state_d = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_d = CLEAR;
      CLEAR:   if (clr_cnt == '1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fold the one-hot group select back into the upper address bits.
  always_comb begin
    grp_bin = '0;
    for (int g = 0; g < gr; g++) begin
      if (s2_grp[g]) grp_bin = gw'(g);
    end
  end

  assign wr_index = {grp_bin, s2_idx};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      clr_cnt   <= '0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_data   <= '0;
      s2_valid  <= 1'b0;
      s2_grp    <= '0;
      s2_idx    <= '0;
      s2_data   <= '0;
      wr_done_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_valid <= wr_valid_i && wr_ready_o;
      if (wr_valid_i && wr_ready_o) begin
        s1_addr <= wr_addr_i;
        s1_data <= wr_data_i;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_grp  <= {{(gr-1){1'b0}}, 1'b1} << s1_addr[address-1 -: gw];
        s2_idx  <= s1_addr[iw-1:0];
        s2_data <= s1_data;
      end
      wr_done_o <= s2_valid;
      if (state_q == DRAIN) clr_cnt <= '0;
      else if (state_q == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // The sweep only runs once the pipeline is empty, so it never races a write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2**address; i++) data_o[i] <= '0;
    end else if (state_q == CLEAR) begin
      data_o[clr_cnt] <= '0;
    end else if (s2_valid) begin
      data_o[wr_index] <= s2_data;
    end
  end

endmodule

// File: tb/tb_demux1to2048_wr_n.sv
// tb/tb_demux1to2048_wr_n.sv - randomized self-checking bench against a cycle-level reference model
module tb_demux1to2048_wr_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_addr;
  logic [3:0]  wr_data;
  logic        clr;
  logic        busy;
  logic        wr_done;
  logic [3:0]  data [0:2047];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux1to2048_wr_n dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .clr_i     (clr),
    .busy_o    (busy),
    .wr_done_o (wr_done),
    .data_o    (data)
  );

  // Reference: pending writes carry the edge at which they become visible.
  typedef struct {
    int       due;
    int       a;
    logic [3:0] d;
  } wr_t;

  wr_t        q[$];
  logic [3:0] ref_mem [0:2047];
  int         e = 0;
  bit         m_busy = 1'b0;
  int         m_cs = 0;
  bit         m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 4'h0;
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 2048; i++) if (data[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic step(input bit v, input int a, input logic [3:0] d, input bit c);
    logic [10:0] a11;
    bit busy0;
    int last;
    a11 = a[10:0];
    wr_valid = v;
    wr_addr  = a11;
    wr_data  = d;
    clr      = c;
    #1;
    chk("wr_ready", wr_ready, !m_busy && !c);
    @(posedge clk);
    e++;
    busy0  = m_busy;
    m_done = 1'b0;
    while (q.size() > 0 && q[0].due == e) begin
      ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
      m_done = 1'b1;
    end
    if (busy0 && e > m_cs && e <= m_cs + 2048) ref_mem[e - m_cs - 1] = 4'h0;
    if (busy0 && e == m_cs + 2048) m_busy = 1'b0;
    if (!busy0 && c) begin
      m_busy = 1'b1;
      last = (q.size() > 0) ? q[q.size()-1].due : e;
      m_cs = ((last > e) ? last : e) + 1;
    end else if (!busy0 && v) begin
      q.push_back('{due: e + 2, a: int'(a11), d: d});
    end
    @(negedge clk);
    chk("wr_done", wr_done, m_done);
    chk("busy", busy, m_busy);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 0, 4'h0, 1'b0);
  endtask

  task automatic settle(input string tag);
    int guard = 0;
    while ((m_busy || q.size() > 0) && guard < 2200) begin
      idle(1);
      guard++;
    end
    chk({tag, "_settle"}, (m_busy || q.size() > 0), 0);
  endtask

  task automatic do_reset(input string tag);
    wr_valid = 1'b0;
    clr      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_mem({tag, "_mem"});
    chk({tag, "_ready"}, wr_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, wr_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sweep_guard;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clr      = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_mem("reset_mem");
    chk("reset_ready", wr_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", wr_done, 0);
    rst_n = 1'b1;

    // single write to the top entry
    step(1'b1, 2047, 4'hA, 1'b0);
    idle(1);
    chk("t2_early", data[2047], 4'h0);
    idle(1);
    chk("t2_data", data[2047], 4'hA);
    check_mem("t2_mem");

    // full-array burst, then same-address back-to-back
    for (int i = 0; i < 2048; i++) step(1'b1, i, i[3:0], 1'b0);
    idle(2);
    check_mem("t3_mem");
    step(1'b1, 5, 4'h1, 1'b0);
    step(1'b1, 5, 4'h2, 1'b0);
    idle(2);
    chk("t3_last_wins", data[5], 4'h2);

    // group boundary
    step(1'b1, 1023, 4'h3, 1'b0);
    step(1'b1, 1024, 4'hC, 1'b0);
    idle(2);
    chk("t4_lo", data[1023], 4'h3);
    chk("t4_hi", data[1024], 4'hC);
    check_mem("t4_mem");

    // random traffic with occasional clears
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)), 4'($urandom),
           $urandom_range(0, 149) == 0);
    settle("rand");
    check_mem("rand_mem");

    // asynchronous reset mid-cycle with writes in flight
    step(1'b1, 300, 4'h9, 1'b0);
    step(1'b1, 301, 4'h8, 1'b0);
    do_reset("t1");

    // clear racing an in-flight write
    step(1'b1, 77, 4'h5, 1'b0);
    idle(2);
    step(1'b1, 10, 4'hF, 1'b0);
    step(1'b1, 11, 4'h3, 1'b1);
    idle(1);
    chk("t5_inflight", data[10], 4'hF);
    chk("t5_busy", busy, 1);
    settle("t5");
    check_mem("t5_mem");
    chk("t5_zero77", data[77], 4'h0);
    chk("t5_zero11", data[11], 4'h0);

    // reset in the middle of the sweep
    for (int i = 0; i < 20; i++) step(1'b1, int'($urandom_range(0, 2047)), 4'($urandom), 1'b0);
    step(1'b0, 0, 4'h0, 1'b1);
    sweep_guard = 0;
    while (e < m_cs + 500 && sweep_guard < 2200) begin
      idle(1);
      sweep_guard++;
    end
    chk("t6_reach", (e == m_cs + 500), 1);
    do_reset("t6");
    step(1'b1, 123, 4'h6, 1'b0);
    idle(1);
    chk("t6_early", data[123], 4'h0);
    idle(1);
    chk("t6_data", data[123], 4'h6);
    check_mem("t6_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
